// File: rtl/nes_oam_dma.sv
// OAM DMA engine at $4014: halts the CPU and copies page $PP00-$PPFF to OAMDATA in get/put pairs.
// Optional OAM_DMA_CYCCNT_EN adds a dma_cycles output reporting the stall length of the last transfer.
module nes_oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int unsigned XFER_LEN      = 256
) (
   input  logic        phi2,
   input  logic        b_rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic        cpu_rnw,
   output logic        cpu_rdy,
   output logic        dma_active,
   output logic [15:0] dma_addr,
   output logic        dma_rd,
   input  logic [7:0]  dma_rdata,
   output logic        dma_we,
   output logic [7:0]  dma_wdata,
   output logic        dma_busy
`ifdef OAM_DMA_CYCCNT_EN
   ,
   output logic [9:0]  dma_cycles
`endif
);

   localparam int unsigned IDX_W = $clog2(XFER_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HALT  = 3'd1;
   localparam logic [2:0] S_ALIGN = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;

   logic [2:0]       state, state_n;
   logic             put;
   logic [7:0]       page, page_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [7:0]       wdata_q, wdata_n;
   logic             trigger;

   logic             rdy_n, active_n, rd_n, we_n, busy_n;
   logic [15:0]      addr_n;
   logic [7:0]       wdata_out_n;

   assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

   // Next-state logic; bus outputs are then decoded from the next state so they come out registered.
   always_comb begin
      state_n = state;
      page_n  = page;
      idx_n   = idx;
      wdata_n = wdata_q;
      case (state)
         S_IDLE: begin
            if (trigger) begin
               page_n  = cpu_wdata;
               idx_n   = '0;
               state_n = S_HALT;
            end
         end
         S_HALT: begin
            // Start reading only once the CPU is on a read; align so READ lands on a get cycle.
            if (cpu_rnw) state_n = put ? S_READ : S_ALIGN;
         end
         S_ALIGN: state_n = S_READ;
         S_READ: begin
            wdata_n = dma_rdata;
            state_n = S_WRITE;
         end
         S_WRITE: begin
            idx_n   = idx + IDX_W'(1);
            state_n = (idx == IDX_LAST) ? S_IDLE : S_READ;
         end
         default: state_n = S_IDLE;
      endcase

      rdy_n    = (state_n == S_IDLE);
      busy_n   = !rdy_n;
      rd_n     = (state_n == S_READ);
      we_n     = (state_n == S_WRITE);
      active_n = rd_n || we_n;
      if (rd_n)      addr_n = {page_n, 8'(idx_n)};
      else if (we_n) addr_n = OAM_DATA_ADDR;
      else           addr_n = 16'h0000;
      wdata_out_n = we_n ? wdata_n : 8'h00;
   end

   // State and registered outputs; reset wins over a same-cycle trigger.
   always_ff @(posedge phi2) begin
      if (b_rst) begin
         state      <= S_IDLE;
         put        <= 1'b0;
         page       <= 8'h00;
         idx        <= '0;
         wdata_q    <= 8'h00;
         cpu_rdy    <= 1'b1;
         dma_busy   <= 1'b0;
         dma_active <= 1'b0;
         dma_rd     <= 1'b0;
         dma_we     <= 1'b0;
         dma_addr   <= 16'h0000;
         dma_wdata  <= 8'h00;
      end else begin
         state      <= state_n;
         put        <= ~put;
         page       <= page_n;
         idx        <= idx_n;
         wdata_q    <= wdata_n;
         cpu_rdy    <= rdy_n;
         dma_busy   <= busy_n;
         dma_active <= active_n;
         dma_rd     <= rd_n;
         dma_we     <= we_n;
         dma_addr   <= addr_n;
         dma_wdata  <= wdata_out_n;
      end
   end

`ifdef OAM_DMA_CYCCNT_EN
   logic [9:0] cyc_cnt;

   // Counts stalled cycles; the result is published only when a transfer completes.
   always_ff @(posedge phi2) begin
      if (b_rst) begin
         cyc_cnt    <= 10'd0;
         dma_cycles <= 10'd0;
      end else begin
         if (state == S_IDLE) begin
            if (trigger) cyc_cnt <= 10'd0;
         end else begin
            cyc_cnt <= cyc_cnt + 10'd1;
         end
         if ((state == S_WRITE) && (state_n == S_IDLE)) dma_cycles <= cyc_cnt + 10'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed bench for nes_oam_dma: stall lengths, source/destination ordering, hold, page wrap, reset abort.
module tb_nes_oam_dma;

   logic        phi2 = 1'b0;
   logic        b_rst;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic        cpu_rnw;
   logic        cpu_rdy;
   logic        dma_active;
   logic [15:0] dma_addr;
   logic        dma_rd;
   logic [7:0]  dma_rdata;
   logic        dma_we;
   logic [7:0]  dma_wdata;
   logic        dma_busy;
`ifdef OAM_DMA_CYCCNT_EN
   logic [9:0]  dma_cycles;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   nes_oam_dma dut (
      .phi2       (phi2),
      .b_rst      (b_rst),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_we     (cpu_we),
      .cpu_rnw    (cpu_rnw),
      .cpu_rdy    (cpu_rdy),
      .dma_active (dma_active),
      .dma_addr   (dma_addr),
      .dma_rd     (dma_rd),
      .dma_rdata  (dma_rdata),
      .dma_we     (dma_we),
      .dma_wdata  (dma_wdata),
      .dma_busy   (dma_busy)
`ifdef OAM_DMA_CYCCNT_EN
      ,
      .dma_cycles (dma_cycles)
`endif
   );

   always #5 phi2 = ~phi2;

   // Cycle index since reset: its parity is the expected put flag.
   always @(posedge phi2) begin
      if (b_rst) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic logic [7:0] src_byte(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
   endfunction

   assign dma_rdata = src_byte(dma_addr);

   task automatic tick;
      @(posedge phi2);
      #1;
   endtask

   task automatic do_reset;
      b_rst = 1'b1; cpu_we = 1'b0; cpu_rnw = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h00;
      tick;
      tick;
      b_rst = 1'b0;
   endtask

   // Write pg to $4014 so that the first HALT cycle has put == halt_put.
   task automatic do_trigger(input logic [7:0] pg, input logic halt_put);
      if ((cyc % 2) != (halt_put ? 0 : 1)) tick;
      cpu_addr = 16'h4014; cpu_wdata = pg; cpu_we = 1'b1; cpu_rnw = 1'b0;
      tick;
      cpu_we = 1'b0; cpu_addr = 16'h8000; cpu_rnw = 1'b1;
   endtask

   // Observe one transfer from the first HALT cycle until cpu_rdy returns.
   task automatic run_xfer(input logic [7:0] pg, input int hold, input int inject_at,
                           output int stalls, output int nrd, output int nwr, output int errs,
                           output int first_k, output logic [15:0] first_rd, output logic [15:0] last_rd);
      stalls = 0; nrd = 0; nwr = 0; errs = 0; first_k = -1; first_rd = 16'h0; last_rd = 16'h0;
      for (int k = 0; k < 2000; k++) begin
         cpu_rnw = (k < hold) ? 1'b0 : 1'b1;
         if (k == inject_at) begin
            cpu_addr = 16'h4014; cpu_wdata = 8'h05; cpu_we = 1'b1;
         end else begin
            cpu_addr = 16'h8000; cpu_we = 1'b0;
         end
         @(negedge phi2);
         if (cpu_rdy) break;
         stalls++;
         if (dma_busy !== 1'b1) errs++;
         if (dma_rd) begin
            if (first_k < 0) begin first_k = k; first_rd = dma_addr; end
            last_rd = dma_addr;
            if (k < hold || dma_addr !== {pg, 8'(nrd)}) errs++;
            nrd++;
         end
         if (dma_we) begin
            if (dma_addr !== 16'h2004 || dma_wdata !== src_byte({pg, 8'(nwr)})) errs++;
            nwr++;
         end
         if (!dma_active && (dma_addr !== 16'h0 || dma_rd || dma_we || dma_wdata !== 8'h0)) errs++;
         @(posedge phi2);
         #1;
      end
      cpu_we = 1'b0; cpu_addr = 16'h8000; cpu_rnw = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      do_reset;
      repeat (4) tick;
      @(negedge phi2);
      tests++; if (cpu_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b want 1", cpu_rdy); end
      tests++; if (dma_active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b want 0", dma_active); end
      tests++; if (dma_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", dma_busy); end
      tests++; if (dma_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h want 0000", dma_addr); end
`ifdef OAM_DMA_CYCCNT_EN
      tests++; if (dma_cycles !== 10'd0) begin fails++; $display("FAIL reset_cycles: got %0d want 0", dma_cycles); end
`endif
      tick;
   endtask

   task automatic test_put_halt;
      int st, nr, nw, er, fk;
      logic [15:0] fr, lr;
      do_trigger(8'h02, 1'b1);
      run_xfer(8'h02, 0, -1, st, nr, nw, er, fk, fr, lr);
      tests++; if (st != 513) begin fails++; $display("FAIL put_stall: got %0d want 513", st); end
      tests++; if (nr != 256) begin fails++; $display("FAIL put_reads: got %0d want 256", nr); end
      tests++; if (nw != 256) begin fails++; $display("FAIL put_writes: got %0d want 256", nw); end
      tests++; if (fr !== 16'h0200) begin fails++; $display("FAIL put_first_rd: got %h want 0200", fr); end
      tests++; if (lr !== 16'h02FF) begin fails++; $display("FAIL put_last_rd: got %h want 02FF", lr); end
      tests++; if (fk != 1) begin fails++; $display("FAIL put_first_k: got %0d want 1", fk); end
      tests++; if (er != 0) begin fails++; $display("FAIL put_seq_errs: got %0d want 0", er); end
`ifdef OAM_DMA_CYCCNT_EN
      tests++; if (dma_cycles !== 10'd513) begin fails++; $display("FAIL put_cycles: got %0d want 513", dma_cycles); end
`endif
   endtask

   task automatic test_get_halt;
      int st, nr, nw, er, fk;
      logic [15:0] fr, lr;
      do_trigger(8'h02, 1'b0);
      run_xfer(8'h02, 0, -1, st, nr, nw, er, fk, fr, lr);
      tests++; if (st != 514) begin fails++; $display("FAIL get_stall: got %0d want 514", st); end
      tests++; if (fk != 2) begin fails++; $display("FAIL get_first_k: got %0d want 2", fk); end
      tests++; if (nw != 256) begin fails++; $display("FAIL get_writes: got %0d want 256", nw); end
      tests++; if (er != 0) begin fails++; $display("FAIL get_seq_errs: got %0d want 0", er); end
`ifdef OAM_DMA_CYCCNT_EN
      tests++; if (dma_cycles !== 10'd514) begin fails++; $display("FAIL get_cycles: got %0d want 514", dma_cycles); end
`endif
   endtask

   task automatic test_halt_hold;
      int st, nr, nw, er, fk;
      logic [15:0] fr, lr;
      do_trigger(8'h11, 1'b0);
      run_xfer(8'h11, 3, -1, st, nr, nw, er, fk, fr, lr);
      tests++; if (st != 516) begin fails++; $display("FAIL hold_stall: got %0d want 516", st); end
      tests++; if (fk != 4) begin fails++; $display("FAIL hold_first_k: got %0d want 4", fk); end
      tests++; if (fr !== 16'h1100) begin fails++; $display("FAIL hold_first_rd: got %h want 1100", fr); end
      tests++; if (er != 0) begin fails++; $display("FAIL hold_seq_errs: got %0d want 0", er); end
   endtask

   task automatic test_page_wrap;
      int st, nr, nw, er, fk;
      logic [15:0] fr, lr;
      do_trigger(8'hFF, 1'b1);
      run_xfer(8'hFF, 0, 100, st, nr, nw, er, fk, fr, lr);
      tests++; if (st != 513) begin fails++; $display("FAIL wrap_stall: got %0d want 513", st); end
      tests++; if (fr !== 16'hFF00) begin fails++; $display("FAIL wrap_first_rd: got %h want FF00", fr); end
      tests++; if (lr !== 16'hFFFF) begin fails++; $display("FAIL wrap_last_rd: got %h want FFFF", lr); end
      tests++; if (nw != 256) begin fails++; $display("FAIL wrap_writes: got %0d want 256", nw); end
      tests++; if (er != 0) begin fails++; $display("FAIL wrap_seq_errs: got %0d want 0", er); end
   endtask

   task automatic test_reset_mid;
      int st, nr, nw, er, fk;
      logic [15:0] fr, lr;
      bit found = 1'b0;
      do_trigger(8'h03, 1'b1);
      for (int k = 0; k < 600; k++) begin
         @(negedge phi2);
         if (dma_rd && dma_addr === 16'h0364) begin found = 1'b1; break; end
         tick;
      end
      tests++; if (found !== 1'b1) begin fails++; $display("FAIL mid_reach_byte100: got %b want 1", found); end
      tick;
      b_rst = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h09;
      tick;
      b_rst = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h8000;
      @(negedge phi2);
      tests++; if (cpu_rdy !== 1'b1) begin fails++; $display("FAIL mid_rdy: got %b want 1", cpu_rdy); end
      tests++; if (dma_active !== 1'b0) begin fails++; $display("FAIL mid_active: got %b want 0", dma_active); end
      tests++; if (dma_we !== 1'b0) begin fails++; $display("FAIL mid_we: got %b want 0", dma_we); end
      tests++; if (dma_busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", dma_busy); end
      tests++; if (dma_addr !== 16'h0000) begin fails++; $display("FAIL mid_addr: got %h want 0000", dma_addr); end
      tick;
      @(negedge phi2);
      tests++; if (cpu_rdy !== 1'b1) begin fails++; $display("FAIL mid_trig_dropped: got rdy %b want 1", cpu_rdy); end
      tick;
      do_trigger(8'h07, 1'b1);
      run_xfer(8'h07, 0, -1, st, nr, nw, er, fk, fr, lr);
      tests++; if (fr !== 16'h0700) begin fails++; $display("FAIL restart_first_rd: got %h want 0700", fr); end
      tests++; if (st != 513) begin fails++; $display("FAIL restart_stall: got %0d want 513", st); end
      tests++; if (nw != 256) begin fails++; $display("FAIL restart_writes: got %0d want 256", nw); end
      tests++; if (er != 0) begin fails++; $display("FAIL restart_seq_errs: got %0d want 0", er); end
   endtask

   initial begin
      b_rst = 1'b1; cpu_we = 1'b0; cpu_rnw = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h00;
      test_reset;
      test_put_halt;
      test_get_halt;
      test_halt_hold;
      test_page_wrap;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
